// File: rtl/mul_share_arbiter.sv
// Shares one 8x8 unsigned multiplier between two requesters; the product goes back to the winner.
// Latency: operands accepted at edge N, product valid from cycle N+1; at most one operation per 2 cycles.
// Backpressure: result held in HOLD until the owner's rsp_ready; both req_ready stay low meanwhile.

module int8_multiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  assign p = 16'(a) * 16'(b);
endmodule

module mul_share_arbiter #(
  parameter bit RR_EN = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [15:0]      rsp_product,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic {IDLE, HOLD} state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } opnd_t;

  state_t      state;
  logic        owner;
  logic        last_grant;
  logic        gnt_vld;
  logic        gnt_sel;
  logic        rsp_take;
  opnd_t       opnd_sel;
  logic [15:0] mul_p;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_sel = 1'b0;
    if (state == IDLE) begin
      gnt_vld = req0_valid | req1_valid;
      if (req0_valid && req1_valid)
        gnt_sel = RR_EN ? ~last_grant : 1'b0;
      else
        gnt_sel = req1_valid;
    end
  end

  assign req0_ready = gnt_vld & ~gnt_sel;
  assign req1_ready = gnt_vld &  gnt_sel;

  // AND-masking rather than a mux keeps X on the losing requester's operands off the product.
  always_comb begin
    opnd_sel   = '0;
    opnd_sel.a = ({8{req0_ready}} & req0_a) | ({8{req1_ready}} & req1_a);
    opnd_sel.b = ({8{req0_ready}} & req0_b) | ({8{req1_ready}} & req1_b);
  end

  int8_multiplier u_mul (
    .a (opnd_sel.a),
    .b (opnd_sel.b),
    .p (mul_p)
  );

  assign rsp_take = owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rsp_product <= 16'h0000;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      busy        <= 1'b0;
      op_count    <= '0;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            rsp_product <= mul_p;
            owner       <= gnt_sel;
            last_grant  <= gnt_sel;
            rsp0_valid  <= ~gnt_sel;
            rsp1_valid  <= gnt_sel;
            busy        <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (rsp_take) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            op_count   <= op_count + CNT_W'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: a round-robin 4-bit-counter instance and a fixed-priority instance share stimulus.
module tb_mul_share_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_ready, rsp1_ready;

  logic        a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_busy;
  logic [15:0] a_rsp_product;
  logic [3:0]  a_op_count;
  logic        b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_busy;
  logic [15:0] b_rsp_product;
  logic [15:0] b_op_count;

  mul_share_arbiter #(.RR_EN(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(a_req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(a_req1_ready),
    .rsp0_valid(a_rsp0_valid), .rsp1_valid(a_rsp1_valid), .rsp_product(a_rsp_product),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready), .busy(a_busy), .op_count(a_op_count)
  );

  mul_share_arbiter #(.RR_EN(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(b_req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(b_req1_ready),
    .rsp0_valid(b_rsp0_valid), .rsp1_valid(b_rsp1_valid), .rsp_product(b_rsp_product),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready), .busy(b_busy), .op_count(b_op_count)
  );

  typedef struct {
    logic        sel;
    logic [15:0] prod;
  } sb_t;

  typedef struct {
    logic        sel;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          stall;
  } vec_t;

  sb_t  sb_q[$];
  vec_t tbl[17];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_a = 0;
  int   exp_b = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("rst_rsp0_valid", a_rsp0_valid, 0);
    chk("rst_rsp1_valid", a_rsp1_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_product", a_rsp_product, 0);
    chk("rst_op_count", a_op_count, 0);
    chk("rst_fp_op_count", b_op_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    exp_a = 0;
    exp_b = 0;
  endtask

  // Called and returns 1 time unit after a rising edge with both instances idle.
  task automatic do_op(input logic sel, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] prod, input int stall);
    sb_t e;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    if (!sel) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
      req1_valid = 1'b0; req1_a = 8'hxx; req1_b = 8'hxx;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
      req0_valid = 1'b0; req0_a = 8'hxx; req0_b = 8'hxx;
    end
    @(negedge clk);
    chk("grant_ready", sel ? a_req1_ready : a_req0_ready, 1);
    chk("grant_other_ready", sel ? a_req0_ready : a_req1_ready, 0);
    e.sel = sel; e.prod = prod;
    sb_q.push_back(e);
    @(posedge clk); #1;
    // The loser raises valid and its rsp_ready during the hold; both must be ignored.
    req0_valid = sel; req1_valid = !sel;
    req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
    if (sel) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("hold_owner_valid", sel ? a_rsp1_valid : a_rsp0_valid, 1);
      chk("hold_other_valid", sel ? a_rsp0_valid : a_rsp1_valid, 0);
      chk("hold_busy", a_busy, 1);
      chk("hold_product", a_rsp_product, sb_q[0].prod);
      chk("hold_ready", {a_req0_ready, a_req1_ready}, 0);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = !sel; rsp1_ready = sel;
    @(negedge clk);
    e = sb_q.pop_front();
    chk("rsp_valid", {a_rsp1_valid, a_rsp0_valid}, e.sel ? 2'b10 : 2'b01);
    chk("rsp_product", a_rsp_product, e.prod);
    @(posedge clk); #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    exp_a = (exp_a + 1) % 16;
    exp_b = exp_b + 1;
    @(negedge clk);
    chk("op_count", a_op_count, exp_a);
    chk("fp_op_count", b_op_count, exp_b);
    chk("drain_busy", a_busy, 0);
    chk("drain_valid", {a_rsp1_valid, a_rsp0_valid}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    sb_t e;
    logic g;
    rst = 1'b1;
    idle_inputs();
    #12;
    do_reset();

    do_op(1'b0, 8'h43, 8'h35, 16'h0DDF, 0);
    do_op(1'b1, 8'hFF, 8'h0F, 16'h0EF1, 5);

    // Continuous contention with responses always accepted.
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF;
    req1_valid = 1'b1; req1_a = 8'h00; req1_b = 8'h7F;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    g = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        chk("rr_req0_ready", a_req0_ready, !g);
        chk("rr_req1_ready", a_req1_ready, g);
        chk("fp_req0_ready", b_req0_ready, 1);
        chk("fp_req1_ready", b_req1_ready, 0);
        e.sel = g; e.prod = g ? 16'h0000 : 16'hFE01;
        sb_q.push_back(e);
      end else begin
        e = sb_q.pop_front();
        chk("rr_rsp_valid", {a_rsp1_valid, a_rsp0_valid}, e.sel ? 2'b10 : 2'b01);
        chk("rr_product", a_rsp_product, e.prod);
        chk("fp_rsp_valid", {b_rsp1_valid, b_rsp0_valid}, 2'b01);
        chk("fp_product", b_rsp_product, 16'hFE01);
        g = ~g;
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    exp_a = (exp_a + 4) % 16;
    exp_b = exp_b + 4;
    @(negedge clk);
    chk("rr_op_count", a_op_count, exp_a);
    chk("fp_op_count_contention", b_op_count, exp_b);
    @(posedge clk); #1;

    // Reset while a 0x0DDF result is pending for requester 0.
    req0_valid = 1'b1; req0_a = 8'h43; req0_b = 8'h35;
    @(negedge clk);
    chk("mid_grant", a_req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("mid_hold_product", a_rsp_product, 16'h0DDF);
    #2 rst = 1'b1;
    #1;
    chk("async_rsp0_valid", a_rsp0_valid, 0);
    chk("async_product", a_rsp_product, 0);
    chk("async_busy", a_busy, 0);
    chk("async_op_count", a_op_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    exp_a = 0; exp_b = 0;
    @(negedge clk);
    chk("post_rst_no_valid", {a_rsp1_valid, a_rsp0_valid}, 0);
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22;
    req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44;
    @(negedge clk);
    chk("post_rst_req0_wins", a_req0_ready, 1);
    chk("post_rst_req1_loses", a_req1_ready, 0);
    @(posedge clk); #1;
    idle_inputs();
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_rsp0_valid", a_rsp0_valid, 1);
    chk("post_rst_product", a_rsp_product, 16'h0242);
    @(posedge clk); #1;
    rsp0_ready = 1'b0;

    // Counter wrap on the 4-bit instance over 17 operations.
    for (int i = 0; i < 17; i++) begin
      tbl[i].sel   = i[0];
      tbl[i].a     = 8'(i * 37 + 5);
      tbl[i].b     = 8'(255 - i * 13);
      tbl[i].prod  = 16'(tbl[i].a) * 16'(tbl[i].b);
      tbl[i].stall = i % 3;
    end
    tbl[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 1};
    tbl[1] = '{1'b1, 8'h00, 8'h7F, 16'h0000, 0};
    tbl[2] = '{1'b0, 8'h80, 8'h02, 16'h0100, 2};
    do_reset();
    for (int i = 0; i < 17; i++) begin
      do_op(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].prod, tbl[i].stall);
      if (i == 14) chk("wrap_after_15", a_op_count, 4'hF);
      if (i == 15) chk("wrap_after_16", a_op_count, 4'h0);
      if (i == 16) chk("wrap_after_17", a_op_count, 4'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
